// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-core datapath: default core size,
// encoder state encoding and the address-event record.
package snn_pkg;

  localparam int unsigned NUM_NEURONS_DEF = 256;
  localparam int unsigned IDX_W_DEF       = $clog2(NUM_NEURONS_DEF);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    EOF     = 2'd2
  } enc_state_e;

  // Address-event beat at the default core size (router-facing view).
  typedef struct packed {
    logic                 eof;
    logic [IDX_W_DEF-1:0] idx;
  } evt_rec_t;

endpackage

// File: rtl/spike_bitmap.sv
// Per-frame spike bitmap: one flop per neuron with independent set, clear
// and read ports. Set and clear never target the same frame phase.
module spike_bitmap
  import snn_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int unsigned IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_en_i,
  input  logic [IDX_W-1:0] set_idx_i,
  input  logic             clr_en_i,
  input  logic [IDX_W-1:0] clr_idx_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_bit_o
);

  logic [NUM_NEURONS-1:0] bits_q, bits_d;

  always_comb begin
    bits_d = bits_q;
    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
      if (set_en_i && (set_idx_i == IDX_W'(i))) bits_d[i] = 1'b1;
      if (clr_en_i && (clr_idx_i == IDX_W'(i))) bits_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) bits_q <= '0;
    else       bits_q <= bits_d;
  end

  assign rd_bit_o = bits_q[rd_idx_i];

endmodule

// File: rtl/spike_event_encoder.sv
// Collects per-neuron spike results into a frame bitmap, then drains it as
// ascending address events on a valid/ready stream followed by an EOF token.
module spike_event_encoder
  import snn_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int unsigned IDX_W       = $clog2(NUM_NEURONS),
  parameter int unsigned CNT_W       = IDX_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             spike_valid_i,
  input  logic             spike_i,
  input  logic [IDX_W-1:0] neuron_idx_i,
  input  logic             frame_done_i,
  output logic             capture_ready_o,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [IDX_W-1:0] evt_idx_o,
  output logic             evt_eof_o,
  output logic             busy_o,
  output logic             idx_err_o
);

  localparam logic [CNT_W-1:0] NUM_C    = CNT_W'(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(NUM_NEURONS - 1);

  typedef struct packed {
    logic             eof;
    logic [IDX_W-1:0] idx;
  } beat_t;

  enc_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  beat_t            evt_q, evt_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;

  logic set_en, clr_en, rd_bit, slot_free;

  spike_bitmap #(
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IDX_W)
  ) u_bitmap (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .set_en_i  (set_en),
    .set_idx_i (neuron_idx_i),
    .clr_en_i  (clr_en),
    .clr_idx_i (ptr_q),
    .rd_idx_i  (ptr_q),
    .rd_bit_o  (rd_bit)
  );

  // The output register can take a new beat when empty or being accepted now.
  assign slot_free = !vld_q || evt_ready_i;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    evt_d   = evt_q;
    vld_d   = vld_q;
    err_d   = err_q;
    set_en  = 1'b0;
    clr_en  = 1'b0;

    case (state_q)
      COLLECT: begin
        if (spike_valid_i && spike_i) begin
          if ({1'b0, neuron_idx_i} < NUM_C) set_en = 1'b1;
          else                              err_d  = 1'b1;
        end
        if (frame_done_i) begin
          state_d = DRAIN;
          ptr_d   = '0;
        end
      end

      DRAIN: begin
        if (slot_free) begin
          vld_d = 1'b0;
          if (rd_bit) begin
            vld_d     = 1'b1;
            evt_d.eof = 1'b0;
            evt_d.idx = ptr_q;
            clr_en    = 1'b1;
            cnt_d     = cnt_q + 1'b1;
          end
          if (ptr_q == LAST_PTR) state_d = EOF;
          else                   ptr_d   = ptr_q + 1'b1;
        end
      end

      EOF: begin
        if (slot_free) begin
          // A held token being accepted ends the frame; otherwise the slot
          // just freed (or was empty) and the token is loaded.
          if (vld_q && evt_q.eof) begin
            vld_d     = 1'b0;
            evt_d.eof = 1'b0;
            cnt_d     = '0;
            state_d   = COLLECT;
          end else begin
            vld_d     = 1'b1;
            evt_d.eof = 1'b1;
            evt_d.idx = cnt_q[IDX_W-1:0];
          end
        end
      end

      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= COLLECT;
      ptr_q   <= '0;
      cnt_q   <= '0;
      evt_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign capture_ready_o = (state_q == COLLECT);
  assign busy_o          = (state_q != COLLECT);
  assign evt_valid_o     = vld_q;
  assign evt_idx_o       = evt_q.idx;
  assign evt_eof_o       = evt_q.eof;
  assign idx_err_o       = err_q;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed bench for spike_event_encoder: a 256-neuron instance for the main
// frame/drain behaviour and a 200-neuron instance for out-of-range indices.
module tb_spike_event_encoder;

  logic       clk = 1'b0;
  logic       rst;

  logic       spike_valid, spike, frame_done, ready;
  logic [7:0] nidx;
  logic       cap_rdy, evt_valid, evt_eof, busy, idx_err;
  logic [7:0] evt_idx;

  logic       b_sv, b_sp, b_fd, b_ready;
  logic [7:0] b_idx;
  logic       b_cap, b_valid, b_eof, b_busy, b_err;
  logic [7:0] b_evt_idx;

  int total = 0;
  int bad   = 0;

  int bq_idx[$];
  int bq_eof[$];
  int bq_cyc[$];

  spike_event_encoder #(.NUM_NEURONS(256)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .spike_valid_i   (spike_valid),
    .spike_i         (spike),
    .neuron_idx_i    (nidx),
    .frame_done_i    (frame_done),
    .capture_ready_o (cap_rdy),
    .evt_valid_o     (evt_valid),
    .evt_ready_i     (ready),
    .evt_idx_o       (evt_idx),
    .evt_eof_o       (evt_eof),
    .busy_o          (busy),
    .idx_err_o       (idx_err)
  );

  spike_event_encoder #(.NUM_NEURONS(200)) dut2 (
    .clk_i           (clk),
    .rst_i           (rst),
    .spike_valid_i   (b_sv),
    .spike_i         (b_sp),
    .neuron_idx_i    (b_idx),
    .frame_done_i    (b_fd),
    .capture_ready_o (b_cap),
    .evt_valid_o     (b_valid),
    .evt_ready_i     (b_ready),
    .evt_idx_o       (b_evt_idx),
    .evt_eof_o       (b_eof),
    .busy_o          (b_busy),
    .idx_err_o       (b_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic report(input logic [7:0] i, input logic s);
    spike_valid = 1'b1;
    spike       = s;
    nidx        = i;
    @(negedge clk);
    spike_valid = 1'b0;
    spike       = 1'b0;
  endtask

  // Called right after frame_done was raised at a negedge (cycle 0). Logs each
  // transferred beat with the cycle it was seen; returns after the EOF accept.
  task automatic drain(input int stall_len, input bit inject);
    bit         seen = 1'b0;
    bit         done = 1'b0;
    int         stall = 0;
    logic [7:0] held = '0;
    bq_idx.delete();
    bq_eof.delete();
    bq_cyc.delete();
    for (int n = 1; n <= 1200 && !done; n++) begin
      @(negedge clk);
      frame_done = 1'b0;
      if (n == 1) begin
        check("busy_in_drain", busy, 1);
        check("cap_rdy_in_drain", cap_rdy, 0);
      end
      if (inject && n == 1) begin
        spike_valid = 1'b1;
        spike       = 1'b1;
        nidx        = 8'd20;
      end else begin
        spike_valid = 1'b0;
        spike       = 1'b0;
      end
      if (stall_len > 0 && !seen && evt_valid) begin
        seen  = 1'b1;
        stall = stall_len;
        held  = evt_idx;
      end
      if (stall > 0) begin
        ready = 1'b0;
        check("stall_hold", {evt_valid, evt_eof, evt_idx}, {1'b1, 1'b0, held});
        stall--;
      end else begin
        ready = 1'b1;
      end
      if (evt_valid && ready) begin
        bq_idx.push_back(int'(evt_idx));
        bq_eof.push_back(int'(evt_eof));
        bq_cyc.push_back(n);
        if (evt_eof) done = 1'b1;
      end
    end
    if (!done) check("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic drain_b();
    bit done = 1'b0;
    bq_idx.delete();
    bq_eof.delete();
    b_ready = 1'b1;
    for (int n = 1; n <= 1200 && !done; n++) begin
      @(negedge clk);
      b_fd = 1'b0;
      if (b_valid) begin
        bq_idx.push_back(int'(b_evt_idx));
        bq_eof.push_back(int'(b_eof));
        if (b_eof) done = 1'b1;
      end
    end
    if (!done) check("b_drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int errs;
    bit got_valid;
    rst = 1'b1;
    spike_valid = 1'b0; spike = 1'b0; nidx = '0; frame_done = 1'b0; ready = 1'b1;
    b_sv = 1'b0; b_sp = 1'b0; b_idx = '0; b_fd = 1'b0; b_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", evt_valid, 0);
    check("rst_eof", evt_eof, 0);
    check("rst_idx", evt_idx, 0);
    check("rst_err", idx_err, 0);
    check("rst_busy", busy, 0);
    check("rst_cap_rdy", cap_rdy, 1);
    rst = 1'b0;
    @(negedge clk);

    // Basic drain: idx 4 reported with spike=0 must not appear.
    report(8'd3, 1'b1);
    report(8'd4, 1'b0);
    report(8'd7, 1'b1);
    frame_done = 1'b1;
    drain(0, 1'b0);
    check("basic_n", bq_idx.size(), 3);
    check("basic_idx0", bq_idx[0], 3);
    check("basic_cyc0", bq_cyc[0], 5);
    check("basic_idx1", bq_idx[1], 7);
    check("basic_cyc1", bq_cyc[1], 9);
    check("basic_eof0", bq_eof[0], 0);
    check("basic_tok_eof", bq_eof[2], 1);
    check("basic_tok_idx", bq_idx[2], 2);
    check("basic_tok_cyc", bq_cyc[2], 258);
    check("basic_busy_after", busy, 0);
    check("basic_valid_after", evt_valid, 0);

    // Zero-spike frame.
    frame_done = 1'b1;
    drain(0, 1'b0);
    check("zero_n", bq_idx.size(), 1);
    check("zero_eof", bq_eof[0], 1);
    check("zero_idx", bq_idx[0], 0);
    check("zero_cyc", bq_cyc[0], 258);
    check("zero_cap_rdy", cap_rdy, 1);

    // Backpressure: ready low for 5 cycles after the first valid.
    report(8'd0, 1'b1);
    report(8'd1, 1'b1);
    report(8'd2, 1'b1);
    frame_done = 1'b1;
    drain(5, 1'b0);
    check("bp_n", bq_idx.size(), 4);
    check("bp_cyc0", bq_cyc[0], 7);
    check("bp_idx0", bq_idx[0], 0);
    check("bp_idx1", bq_idx[1], 1);
    check("bp_idx2", bq_idx[2], 2);
    check("bp_eofs", {bq_eof[0][0], bq_eof[1][0], bq_eof[2][0], bq_eof[3][0]}, 4'b0001);
    check("bp_tok_idx", bq_idx[3], 3);

    // Duplicate, spike coincident with frame_done, spike during drain.
    report(8'd5, 1'b1);
    report(8'd5, 1'b1);
    spike_valid = 1'b1; spike = 1'b1; nidx = 8'd9; frame_done = 1'b1;
    drain(0, 1'b1);
    check("dup_n", bq_idx.size(), 3);
    check("dup_idx0", bq_idx[0], 5);
    check("dup_idx1", bq_idx[1], 9);
    check("dup_tok", {bq_eof[2][0], bq_idx[2][7:0]}, {1'b1, 8'd2});

    // Full frame: count of 256 wraps to 0 in the token.
    for (int i = 0; i < 256; i++) report(8'(i), 1'b1);
    frame_done = 1'b1;
    drain(0, 1'b0);
    check("full_n", bq_idx.size(), 257);
    errs = 0;
    for (int i = 0; i < 256 && i < bq_idx.size(); i++)
      if (bq_idx[i] != i || bq_eof[i] != 0) errs++;
    check("full_order_errs", errs, 0);
    check("full_tok", {bq_eof[256][0], bq_idx[256][7:0]}, {1'b1, 8'd0});

    // Reset while an event is held under backpressure.
    report(8'd10, 1'b1);
    report(8'd30, 1'b1);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    ready = 1'b0;
    got_valid = 1'b0;
    for (int n = 0; n < 40 && !got_valid; n++) begin
      if (evt_valid) got_valid = 1'b1;
      else @(negedge clk);
    end
    check("mrst_pre_valid", evt_valid, 1);
    check("mrst_pre_idx", evt_idx, 10);
    #2 rst = 1'b1;
    #1;
    check("mrst_valid", evt_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_cap_rdy", cap_rdy, 1);
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    report(8'd1, 1'b1);
    frame_done = 1'b1;
    drain(0, 1'b0);
    check("mrst_n", bq_idx.size(), 2);
    check("mrst_idx0", {bq_eof[0][0], bq_idx[0][7:0]}, {1'b0, 8'd1});
    check("mrst_tok", {bq_eof[1][0], bq_idx[1][7:0]}, {1'b1, 8'd1});

    // Out-of-range index on the 200-neuron instance; 199 is the last valid one.
    check("oor_err_init", b_err, 0);
    b_sv = 1'b1; b_sp = 1'b1; b_idx = 8'd250;
    @(negedge clk);
    check("oor_err_set", b_err, 1);
    b_idx = 8'd199;
    @(negedge clk);
    b_sv = 1'b0; b_sp = 1'b0;
    b_fd = 1'b1;
    drain_b();
    check("oor_n", bq_idx.size(), 2);
    check("oor_idx0", {bq_eof[0][0], bq_idx[0][7:0]}, {1'b0, 8'd199});
    check("oor_tok", {bq_eof[1][0], bq_idx[1][7:0]}, {1'b1, 8'd1});
    b_fd = 1'b1;
    drain_b();
    check("oor_zero_n", bq_idx.size(), 1);
    check("oor_err_sticky", b_err, 1);
    check("oor_b_busy", b_busy, 0);
    check("oor_b_cap", b_cap, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
